// File: rtl/rr_selector_if.sv
// rtl/rr_selector_if.sv - request/data/grant and output handshake bundle for rr_selector
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

interface rr_selector_if #(
  parameter int DATA = 8,
  parameter int IN   = 8
);
  localparam int LOG2_IN = $clog2(IN);

  logic [IN-1:0]            req;
  logic [IN-1:0][DATA-1:0]  in;
  logic [IN-1:0]            grant;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA-1:0]          out;
  logic [LOG2_IN-1:0]       out_idx;

  // Requesters and the downstream consumer sit on the master side.
  modport master (
    output req,
    output in,
    output out_ready,
    input  grant,
    input  out_valid,
    input  out,
    input  out_idx
  );

  // The selector itself.
  modport slave (
    input  req,
    input  in,
    input  out_ready,
    output grant,
    output out_valid,
    output out,
    output out_idx
  );
endinterface

// File: rtl/rr_selector.sv
// rtl/rr_selector.sv - N-way request selector (fixed LSB/MSB or round-robin) with a one-deep registered output
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module rr_selector #(
  parameter int   DATA = 8,
  parameter int   IN   = 8,
  parameter logic ACT  = `High,
  parameter int   MODE = 2
) (
  input  logic           clk,
  input  logic           reset_,
  rr_selector_if.slave   bus
);
  localparam int LOG2_IN = $clog2(IN);

  logic [IN-1:0]      active;
  logic               found;
  logic [LOG2_IN-1:0] sel;
  logic               accept;
  logic [IN-1:0]      grant_vec;
  logic [LOG2_IN-1:0] ptr;
  logic [LOG2_IN-1:0] ptr_nxt;
  logic               run;
  logic               out_valid_r;
  logic [DATA-1:0]    out_r;
  logic [LOG2_IN-1:0] out_idx_r;

  // Normalise request polarity so the search below only looks for ones.
  assign active = ACT ? bus.req : ~bus.req;

  // Winner search; the grant never looks at the data lanes.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    if (MODE == 0) begin
      for (int i = 0; i < IN; i++) begin
        if (!found && active[i]) begin
          found = 1'b1;
          sel   = LOG2_IN'(i);
        end
      end
    end else if (MODE == 1) begin
      for (int i = IN - 1; i >= 0; i--) begin
        if (!found && active[i]) begin
          found = 1'b1;
          sel   = LOG2_IN'(i);
        end
      end
    end else begin
      // Walk upward from ptr, folding back below IN so odd channel counts wrap correctly.
      for (int k = 0; k < IN; k++) begin
        idx = int'(ptr) + k;
        if (idx >= IN) begin
          idx = idx - IN;
        end
        if (!found && active[idx]) begin
          found = 1'b1;
          sel   = LOG2_IN'(idx);
        end
      end
    end
  end

  // Accept only when the output slot is free or draining this cycle, and never
  // before the first clock after reset release so the release edge cannot grant.
  always_comb begin
    accept    = run && found && (!out_valid_r || bus.out_ready);
    grant_vec = '0;
    if (accept) begin
      grant_vec[sel] = 1'b1;
    end
  end

  // Round-robin pointer advances just past the winner, wrapping at IN-1.
  always_comb begin
    ptr_nxt = ptr;
    if (accept && (MODE == 2)) begin
      if (sel == LOG2_IN'(IN - 1)) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = sel + 1'b1;
      end
    end
  end

  // Output register, pointer and the post-reset run flag.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      run         <= 1'b0;
      ptr         <= '0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      out_idx_r   <= '0;
    end else begin
      run <= 1'b1;
      ptr <= ptr_nxt;
      if (accept) begin
        out_valid_r <= 1'b1;
        out_r       <= bus.in[sel];
        out_idx_r   <= sel;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.grant     = grant_vec;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.out_idx   = out_idx_r;
endmodule
